multi_debounce_counter: RTL and testbench
=========================================

# multi_debounce_counter

Parametrised, multi-channel debounce verification block: each of `N` raw switch inputs gets its own synchroniser, debounce FSMD and a pair of event counters. One counter counts raw (un-debounced) rising edges and one counts debounced rising edges, so bounce activity is directly measurable per channel. A channel selector exposes one channel's counter pair to the seven-segment display multiplexer. The block replaces the single-channel, fixed-width debounce test circuit and adds configurable width, wrap/saturate mode, overflow flags and per-channel outputs.

## Interface
- `N`, 2: number of channels, at least 1.
- `CW`, 8: width of each event counter.
- `DB_CYCLES`, 2_000_000: stable-sample count required to accept a level change, at least 1 (20 ms at 100 MHz).
- `SAT`, 0: counter mode. 0 = wrap, 1 = saturate.
- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sw`  in  N  raw asynchronous switch/button inputs.
- `clr`  in  1  synchronous clear of all counters and overflow flags.
- `sel`  in  max(1, clog2(N))  channel select for `raw_cnt`/`db_cnt`.
- `raw_cnt`  out  CW  raw rising-edge count of the selected channel.
- `db_cnt`  out  CW  debounced rising-edge count of the selected channel.
- `db_level`  out  N  debounced level per channel.
- `db_tick`  out  N  one-cycle pulse per channel on each debounced rising edge.
- `ovf`  out  N  sticky overflow flag per channel.

## Operation
- **Synchroniser.** Per channel, two flops turn `sw[i]` into `s[i]`. A third flop holds the previous `s[i]`.
- **Raw edge.** `raw_tick[i] = s[i] & ~prev[i]`. Raw edges are counted after synchronisation, never on the raw pin.
- **Debounce FSMD.** Per channel, four states plus a down-timer of width clog2(DB_CYCLES+1).
  - `ZERO`: if `s=1`, load timer with DB_CYCLES-1 and go to `WAIT1`.
  - `WAIT1`: if `s=0`, go to `ZERO`. Otherwise, if timer==0, go to `ONE` and pulse `db_tick`; else decrement.
  - `ONE`: if `s=0`, load timer with DB_CYCLES-1 and go to `WAIT0`.
  - `WAIT0`: if `s=1`, go to `ONE` with no tick. Otherwise, if timer==0, go to `ZERO`; else decrement.
- `db_level=1` in `ONE` and `WAIT0`. `db_tick` is registered and is high exactly in the first cycle of `ONE` entered from `WAIT1`.
- **Counters.** Each channel has independent `raw` and `db` counters of CW bits.
  - Increment on `raw_tick` and `db_tick` respectively.
  - `clr` has priority over increment in the same cycle. It zeroes both counters and `ovf` of every channel.
  - `clr` does not affect the synchronisers or the FSMs.
- **Wrap mode (`SAT=0`).** All-ones +1 gives 0 and sets `ovf[i]`.
- **Saturate mode (`SAT=1`).** A counter at all-ones holds its value. An attempted increment sets `ovf[i]`.
- `ovf[i]` is set by either counter of channel `i`. It clears only on `clr` or reset.
- **Output mux.** `raw_cnt`/`db_cnt` select channel `sel` combinationally. If `sel >= N`, both outputs are 0.

## Timing
- **Reset.** While `reset=0`, all of the following are 0 immediately, without waiting for a clock:
  - synchroniser flops and timers;
  - FSMs in `ZERO`;
  - counters, `ovf`, `db_level`, `db_tick`, `raw_cnt`, `db_cnt`.
- **Press latency.** `sw[i]` is held high; edge 1 is the first edge that samples it high.
  - `s[i]` is high after edge 2.
  - The raw counter increments at edge 3.
  - `db_level[i]` and `db_tick[i]` rise after edge DB_CYCLES+3.
  - The debounced counter increments at edge DB_CYCLES+4.
- **Release latency.** `db_level[i]` falls after edge DB_CYCLES+3, counted the same way from the release.
- **Glitch rejection.** A low or high glitch shorter than DB_CYCLES+1 synchronised samples causes no level change and no tick.
- **Reset mid-operation.** Any partially elapsed timer is discarded. After reset is released, the full latency applies again.
- **Simultaneous events.**
  - Channels are fully independent; ticks on several channels in one cycle are all counted.
  - `raw_tick` and `db_tick` on the same channel in the same cycle both count.

## Test plan
Parameters for all scenarios: N=2, CW=4, DB_CYCLES=4, SAT=0 unless stated.
- **Clean press.** `sw[0]` high for 20 cycles -> `db_level[0]` rises after edge 7, `db_tick[0]` high for exactly 1 cycle, `sel=0` shows `raw_cnt=1`, `db_cnt=1`; channel 1 counts stay 0.
- **Bounce.** `sw[1]` toggles 1,0,1,0,1 with 2 cycles per level, then stays high 20 cycles -> `sel=1` shows `raw_cnt=3`, `db_cnt=1`; exactly one `db_tick[1]`.
- **Release glitch.** In `ONE`, a 2-cycle low pulse on `sw[0]` -> `db_level[0]` stays 1, no `db_tick`, `db_cnt` unchanged.
- **Overflow.** 17 clean presses on channel 0 -> with `SAT=0`, `db_cnt=1`, `raw_cnt=1`, `ovf[0]=1`, `ovf[1]=0`. With `SAT=1`, both counts are 15 and `ovf[0]=1`.
- **Clear collision.** `clr` asserted in the same cycle as a `db_tick[0]` increment -> counts 0 and `ovf=0` after the edge; the next clean press gives `db_cnt=1`. `sel=3` -> both outputs 0.
- **Reset mid-wait.** `reset` low while channel 0 is in `WAIT1` with timer 2 -> all outputs 0 without a clock edge. After release with `sw[0]` held high, `db_level[0]` rises only after the full DB_CYCLES+3 edges.

Source files
------------

// File: rtl/multi_debounce_counter.sv
// rtl/multi_debounce_counter.sv - per-channel sync, debounce FSMD and raw/debounced edge counters
module multi_debounce_counter #(
    parameter int N         = 2,
    parameter int CW        = 8,
    parameter int DB_CYCLES = 2_000_000,
    parameter int SAT       = 0,
    localparam int SW       = (N > 1) ? $clog2(N) : 1,
    localparam int TW       = $clog2(DB_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  sw,
    input  logic          clr,
    input  logic [SW-1:0] sel,
    output logic [CW-1:0] raw_cnt,
    output logic [CW-1:0] db_cnt,
    output logic [N-1:0]  db_level,
    output logic [N-1:0]  db_tick,
    output logic [N-1:0]  ovf
);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(DB_CYCLES - 1);

    logic [N*CW-1:0] raw_flat;
    logic [N*CW-1:0] db_flat;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1_q, s_q, prev_q;
        logic          raw_tick;
        db_state_t     state_q;
        logic [TW-1:0] timer_q;
        logic          tick_q;
        logic [CW-1:0] raw_q, raw_d, db_q, db_d;
        logic          ovf_q, ovf_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
                prev_q  <= 1'b0;
            end else begin
                sync1_q <= sw[i];
                s_q     <= sync1_q;
                prev_q  <= s_q;
            end
        end

        assign raw_tick = s_q & ~prev_q;

        // The timer only runs while the synchronised level disagrees with the accepted level.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ZERO;
                timer_q <= '0;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                case (state_q)
                    ZERO: begin
                        if (s_q) begin
                            timer_q <= TIMER_LOAD;
                            state_q <= WAIT1;
                        end
                    end
                    WAIT1: begin
                        if (!s_q) begin
                            state_q <= ZERO;
                        end else if (timer_q == '0) begin
                            state_q <= ONE;
                            tick_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    ONE: begin
                        if (!s_q) begin
                            timer_q <= TIMER_LOAD;
                            state_q <= WAIT0;
                        end
                    end
                    WAIT0: begin
                        if (s_q) begin
                            state_q <= ONE;
                        end else if (timer_q == '0) begin
                            state_q <= ZERO;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    default: state_q <= ZERO;
                endcase
            end
        end

        always_comb begin
            raw_d = raw_q;
            db_d  = db_q;
            ovf_d = ovf_q;
            if (clr) begin
                raw_d = '0;
                db_d  = '0;
                ovf_d = 1'b0;
            end else begin
                if (raw_tick) begin
                    if (raw_q == '1) begin
                        ovf_d = 1'b1;
                        if (SAT == 0) raw_d = '0;
                    end else begin
                        raw_d = raw_q + CW'(1);
                    end
                end
                if (tick_q) begin
                    if (db_q == '1) begin
                        ovf_d = 1'b1;
                        if (SAT == 0) db_d = '0;
                    end else begin
                        db_d = db_q + CW'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                raw_q <= '0;
                db_q  <= '0;
                ovf_q <= 1'b0;
            end else begin
                raw_q <= raw_d;
                db_q  <= db_d;
                ovf_q <= ovf_d;
            end
        end

        assign raw_flat[i*CW +: CW] = raw_q;
        assign db_flat[i*CW +: CW]  = db_q;
        assign db_level[i]          = (state_q == ONE) || (state_q == WAIT0);
        assign db_tick[i]           = tick_q;
        assign ovf[i]               = ovf_q;
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        raw_cnt = '0;
        db_cnt  = '0;
        for (int j = 0; j < N; j++) begin
            if (sel == SW'(j)) begin
                raw_cnt = raw_flat[j*CW +: CW];
                db_cnt  = db_flat[j*CW +: CW];
            end
        end
    end

endmodule

// File: tb/tb_multi_debounce_counter.sv
// tb/tb_multi_debounce_counter.sv - scoreboard bench for multi_debounce_counter
module tb_multi_debounce_counter;

    localparam int K_RAW = 0, K_DB = 1, K_LVL = 2, K_TICK = 3, K_OVF = 4;

    logic       clk = 1'b0;
    logic       reset, clr;
    logic [1:0] sw;
    logic       sel0;
    logic [1:0] sel1;
    logic [3:0] raw0, db0, raw1, db1;
    logic [1:0] lvl0, tick0, ovf0;
    logic [2:0] lvl1, tick1, ovf1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string name;
        int    dut;
        int    kind;
        int    exp;
    } chk_t;
    typedef struct {
        int ch;
        int cyc;
    } tick_t;

    chk_t  chk_q[$];
    tick_t tick_q[$];

    multi_debounce_counter #(.N(2), .CW(4), .DB_CYCLES(4), .SAT(0)) dut0 (
        .clk(clk), .reset(reset), .sw(sw), .clr(clr), .sel(sel0),
        .raw_cnt(raw0), .db_cnt(db0), .db_level(lvl0), .db_tick(tick0), .ovf(ovf0)
    );

    multi_debounce_counter #(.N(3), .CW(4), .DB_CYCLES(4), .SAT(1)) dut1 (
        .clk(clk), .reset(reset), .sw({1'b0, sw}), .clr(clr), .sel(sel1),
        .raw_cnt(raw1), .db_cnt(db1), .db_level(lvl1), .db_tick(tick1), .ovf(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(int dut, int kind);
        if (dut == 0) begin
            case (kind)
                K_RAW:   return int'(raw0);
                K_DB:    return int'(db0);
                K_LVL:   return int'(lvl0);
                K_TICK:  return int'(tick0);
                default: return int'(ovf0);
            endcase
        end
        case (kind)
            K_RAW:   return int'(raw1);
            K_DB:    return int'(db1);
            K_LVL:   return int'(lvl1);
            K_TICK:  return int'(tick1);
            default: return int'(ovf1);
        endcase
    endfunction

    function automatic void expect_v(string name, int dut, int kind, int exp);
        chk_t c;
        c.name = name;
        c.dut  = dut;
        c.kind = kind;
        c.exp  = exp;
        chk_q.push_back(c);
    endfunction

    function automatic void expect_tick(int ch, int at);
        tick_t t;
        t.ch  = ch;
        t.cyc = at;
        tick_q.push_back(t);
    endfunction

    task automatic sync_chk();
        @(negedge clk);
        #1;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press0(int hold_hi, int hold_lo);
        sw[0] = 1'b1;
        expect_tick(0, cyc + 7);
        step(hold_hi);
        sw[0] = 1'b0;
        step(hold_lo);
    endtask

    // Monitor: debounced ticks against the expected-tick queue, snapshots against the check queue.
    chk_t  mc;
    tick_t mt;
    int    ma;
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (tick0[ch]) begin
                checks++;
                if (tick_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tick: ch=%0d at cyc=%0d, expected no tick", ch, cyc);
                end else begin
                    mt = tick_q.pop_front();
                    if (mt.ch != ch || mt.cyc != cyc) begin
                        failures++;
                        $display("FAIL tick_timing: got ch=%0d cyc=%0d, expected ch=%0d cyc=%0d",
                                 ch, cyc, mt.ch, mt.cyc);
                    end
                end
            end
        end
        while (chk_q.size() > 0) begin
            mc = chk_q.pop_front();
            ma = actual(mc.dut, mc.kind);
            checks++;
            if (ma != mc.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d (cyc %0d)", mc.name, ma, mc.exp, cyc);
            end
        end
    end

    initial begin
        reset = 1'b0;
        clr   = 1'b0;
        sw    = 2'b00;
        sel0  = 1'b0;
        sel1  = 2'd0;
        #2;
        expect_v("rst_raw", 0, K_RAW, 0);
        expect_v("rst_db", 0, K_DB, 0);
        expect_v("rst_lvl", 0, K_LVL, 0);
        expect_v("rst_tick", 0, K_TICK, 0);
        expect_v("rst_ovf", 0, K_OVF, 0);
        sync_chk();
        step(3);
        reset = 1'b1;
        step(3);

        // Clean press on channel 0
        sw[0] = 1'b1;
        expect_tick(0, cyc + 7);
        step(6);
        expect_v("press_lvl_e6", 0, K_LVL, 0);
        sync_chk();
        step(1);
        expect_v("press_lvl_e7", 0, K_LVL, 1);
        expect_v("press_tick_e7", 0, K_TICK, 1);
        sync_chk();
        step(1);
        expect_v("press_tick_e8", 0, K_TICK, 0);
        sync_chk();
        step(12);
        sel0 = 1'b0;
        expect_v("press_raw0", 0, K_RAW, 1);
        expect_v("press_db0", 0, K_DB, 1);
        sync_chk();
        sel0 = 1'b1;
        expect_v("press_raw1", 0, K_RAW, 0);
        expect_v("press_db1", 0, K_DB, 0);
        sync_chk();

        // Bounce on channel 1
        step(1);
        sw[1] = 1'b1; step(2);
        sw[1] = 1'b0; step(2);
        sw[1] = 1'b1; step(2);
        sw[1] = 1'b0; step(2);
        sw[1] = 1'b1;
        expect_tick(1, cyc + 7);
        step(20);
        sel0 = 1'b1;
        expect_v("bounce_raw1", 0, K_RAW, 3);
        expect_v("bounce_db1", 0, K_DB, 1);
        sync_chk();

        // Low glitch on channel 0 while in ONE
        step(1);
        sw[0] = 1'b0;
        step(2);
        sw[0] = 1'b1;
        step(15);
        sel0 = 1'b0;
        expect_v("glitch_lvl", 0, K_LVL, 3);
        expect_v("glitch_db0", 0, K_DB, 1);
        expect_v("glitch_raw0", 0, K_RAW, 2);
        sync_chk();

        // Release latency on both channels
        step(1);
        sw = 2'b00;
        step(6);
        expect_v("release_lvl_e6", 0, K_LVL, 3);
        sync_chk();
        step(1);
        expect_v("release_lvl_e7", 0, K_LVL, 0);
        sync_chk();
        step(10);

        // Overflow: 17 presses, wrap on dut0 and saturate on dut1
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        for (int p = 0; p < 17; p++) press0(12, 12);
        sel0 = 1'b0;
        sel1 = 2'd0;
        expect_v("wrap_raw", 0, K_RAW, 1);
        expect_v("wrap_db", 0, K_DB, 1);
        expect_v("wrap_ovf", 0, K_OVF, 1);
        expect_v("sat_raw", 1, K_RAW, 15);
        expect_v("sat_db", 1, K_DB, 15);
        expect_v("sat_ovf", 1, K_OVF, 1);
        sync_chk();

        // clr in the same cycle as a db_tick increment
        step(1);
        sw[0] = 1'b1;
        expect_tick(0, cyc + 7);
        step(7);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        expect_v("clr_raw", 0, K_RAW, 0);
        expect_v("clr_db", 0, K_DB, 0);
        expect_v("clr_ovf", 0, K_OVF, 0);
        expect_v("clr_ovf_sat", 1, K_OVF, 0);
        sync_chk();
        step(5);
        sw[0] = 1'b0;
        step(12);
        press0(12, 12);
        expect_v("post_clr_raw", 0, K_RAW, 1);
        expect_v("post_clr_db", 0, K_DB, 1);
        sync_chk();
        sel1 = 2'd3;
        expect_v("sel_oob_raw", 1, K_RAW, 0);
        expect_v("sel_oob_db", 1, K_DB, 0);
        sync_chk();
        sel1 = 2'd0;
        expect_v("sel0_raw", 1, K_RAW, 1);
        expect_v("sel0_db", 1, K_DB, 1);
        sync_chk();

        // Reset while channel 0 is in WAIT1 with timer 2
        step(1);
        sw[0] = 1'b1;
        step(4);
        reset = 1'b0;
        #1;
        expect_v("midrst_raw", 0, K_RAW, 0);
        expect_v("midrst_db", 0, K_DB, 0);
        expect_v("midrst_lvl", 0, K_LVL, 0);
        expect_v("midrst_tick", 0, K_TICK, 0);
        expect_v("midrst_ovf", 0, K_OVF, 0);
        sync_chk();
        step(3);
        reset = 1'b1;
        expect_tick(0, cyc + 7);
        step(6);
        expect_v("midrst_lvl_e6", 0, K_LVL, 0);
        sync_chk();
        step(1);
        expect_v("midrst_lvl_e7", 0, K_LVL, 1);
        sync_chk();
        step(5);
        expect_v("midrst_raw_after", 0, K_RAW, 1);
        expect_v("midrst_db_after", 0, K_DB, 1);
        sync_chk();

        step(20);
        checks++;
        if (tick_q.size() != 0) begin
            failures++;
            $display("FAIL missing_ticks: got %0d pending, expected 0", tick_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
